// File: rtl/mvf_block_scheduler.sv
// Raster-order block scheduler for the motion-vector-field path: requests one block at a time and writes each returned vector to the MVF store.
// Optional MVF_TIMEOUT_EN: bounds the wait for a vector and substitutes a zero vector on expiry.
module mvf_block_scheduler #(
    parameter int DIM_W   = 8,
    parameter int MV_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic [DIM_W-1:0]     height,
    input  logic [DIM_W-1:0]     width,
    input  logic                 Vector_sig,
    input  logic [MV_W-1:0]      mv_x,
    input  logic [MV_W-1:0]      mv_y,
    input  logic                 wr_ready,
    output logic                 Nxt_block_sig,
    output logic [DIM_W-1:0]     addr_x,
    output logic [DIM_W-1:0]     addr_y,
    output logic                 mvf_wr_en,
    output logic [2*DIM_W-1:0]   mvf_wr_addr,
    output logic [2*MV_W-1:0]    mvf_wr_data,
    output logic                 busy,
    output logic                 MVF_complete_sig,
    output logic                 timeout_flag
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_MV, WRITE, DONE} state_t;

    state_t               state_q, state_d;
    logic [DIM_W-1:0]     height_q, height_d;
    logic [DIM_W-1:0]     width_q, width_d;
    logic [DIM_W-1:0]     addr_x_q, addr_x_d;
    logic [DIM_W-1:0]     addr_y_q, addr_y_d;
    logic [2*DIM_W-1:0]   wr_addr_q, wr_addr_d;
    logic [2*MV_W-1:0]    mv_q, mv_d;
    logic                 timeout_q, timeout_d;
    logic                 mv_timeout;
    logic                 last_col;
    logic                 last_blk;

`ifdef MVF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_hit;

    // Counter value after this cycle's increment; expiry lands the FSM in WRITE TIMEOUT+1 cycles after REQ.
    always_comb begin
        cnt_d   = cnt_q;
        cnt_hit = 1'b0;
        if (enable) begin
            if (state_q == REQ) begin
                cnt_d = '0;
            end else if (state_q == WAIT_MV) begin
                cnt_d   = cnt_q + CNT_W'(1);
                cnt_hit = (cnt_d == CNT_W'(TIMEOUT));
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mv_timeout = cnt_hit & ~Vector_sig;
`else
    assign mv_timeout = 1'b0;
`endif

    assign last_col = (addr_x_q == width_q - DIM_W'(1));
    assign last_blk = last_col && (addr_y_q == height_q - DIM_W'(1));

    always_comb begin
        state_d   = state_q;
        height_d  = height_q;
        width_d   = width_q;
        addr_x_d  = addr_x_q;
        addr_y_d  = addr_y_q;
        wr_addr_d = wr_addr_q;
        mv_d      = mv_q;
        timeout_d = timeout_q;
        if (enable) begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        height_d  = height;
                        width_d   = width;
                        addr_x_d  = '0;
                        addr_y_d  = '0;
                        wr_addr_d = '0;
                        timeout_d = 1'b0;
                        state_d   = (height == '0 || width == '0) ? DONE : REQ;
                    end
                end
                REQ: state_d = WAIT_MV;
                WAIT_MV: begin
                    if (Vector_sig) begin
                        mv_d    = {mv_y, mv_x};
                        state_d = WRITE;
                    end else if (mv_timeout) begin
                        mv_d      = '0;
                        timeout_d = 1'b1;
                        state_d   = WRITE;
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        // Linear index tracks raster order, so a running count replaces y*width+x.
                        wr_addr_d = wr_addr_q + (2*DIM_W)'(1);
                        if (last_col) begin
                            addr_x_d = '0;
                            addr_y_d = addr_y_q + DIM_W'(1);
                        end else begin
                            addr_x_d = addr_x_q + DIM_W'(1);
                        end
                        state_d = last_blk ? DONE : REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            height_q  <= '0;
            width_q   <= '0;
            addr_x_q  <= '0;
            addr_y_q  <= '0;
            wr_addr_q <= '0;
            mv_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            height_q  <= height_d;
            width_q   <= width_d;
            addr_x_q  <= addr_x_d;
            addr_y_q  <= addr_y_d;
            wr_addr_q <= wr_addr_d;
            mv_q      <= mv_d;
            timeout_q <= timeout_d;
        end
    end

    assign Nxt_block_sig    = enable && (state_q == REQ);
    assign mvf_wr_en        = (state_q == WRITE);
    assign busy             = (state_q == REQ) || (state_q == WAIT_MV) || (state_q == WRITE);
    assign MVF_complete_sig = (state_q == DONE);
    assign addr_x           = addr_x_q;
    assign addr_y           = addr_y_q;
    assign mvf_wr_addr      = wr_addr_q;
    assign mvf_wr_data      = mv_q;
    assign timeout_flag     = timeout_q;

endmodule

// File: tb/tb_mvf_block_scheduler.sv
// Scoreboard bench for mvf_block_scheduler: expected requests and writes are queued per frame and popped as the DUT emits them.
module tb_mvf_block_scheduler;
    localparam int DIM_W = 8;
    localparam int MV_W  = 8;

    logic                 CLK = 1'b0;
    logic                 reset, enable, start, Vector_sig, wr_ready;
    logic [DIM_W-1:0]     height, width;
    logic [MV_W-1:0]      mv_x, mv_y;
    logic                 Nxt_block_sig, mvf_wr_en, busy, MVF_complete_sig, timeout_flag;
    logic [DIM_W-1:0]     addr_x, addr_y;
    logic [2*DIM_W-1:0]   mvf_wr_addr;
    logic [2*MV_W-1:0]    mvf_wr_data;

    int total = 0;
    int bad   = 0;

    logic [2*DIM_W-1:0]         exp_req_q[$];
    logic [2*DIM_W+2*MV_W-1:0]  exp_wr_q[$];
    logic [2*MV_W-1:0]          send_mv[64];

    mvf_block_scheduler #(.DIM_W(DIM_W), .MV_W(MV_W), .TIMEOUT(8)) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .start(start),
        .height(height), .width(width), .Vector_sig(Vector_sig),
        .mv_x(mv_x), .mv_y(mv_y), .wr_ready(wr_ready),
        .Nxt_block_sig(Nxt_block_sig), .addr_x(addr_x), .addr_y(addr_y),
        .mvf_wr_en(mvf_wr_en), .mvf_wr_addr(mvf_wr_addr), .mvf_wr_data(mvf_wr_data),
        .busy(busy), .MVF_complete_sig(MVF_complete_sig), .timeout_flag(timeout_flag)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] all_outs();
        return 64'({Nxt_block_sig, addr_x, addr_y, mvf_wr_en, mvf_wr_addr, mvf_wr_data,
                    busy, MVF_complete_sig, timeout_flag});
    endfunction

    // Runs one frame h x w. Estimator answers dly cycles after each request; block stall_blk
    // sees wr_ready low for stall_len cycles; block drop_blk gets no vector at all.
    task automatic run_frame(input int h, input int w, input int dly, input int stall_blk,
                             input int stall_len, input bit fixed_mv, input bit inject_start,
                             input int drop_blk);
        int n = h * w;
        int reqs = 0, wrs = 0, pend = 0, cyc = 0, last_req_cyc = -1;
        int stall_left = stall_len, en_cnt = 0, wait_blk = 0, blk;
        bit done = 0, last_acc = 0;
        logic [2*DIM_W-1:0] ra;
        logic [2*DIM_W+2*MV_W-1:0] we;
        exp_req_q.delete();
        exp_wr_q.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                blk = y * w + x;
                send_mv[blk] = fixed_mv ? 16'hFF01 : 16'($urandom);
                exp_req_q.push_back({DIM_W'(y), DIM_W'(x)});
                exp_wr_q.push_back({(2*DIM_W)'(blk), (blk == drop_blk) ? 16'h0000 : send_mv[blk]});
            end
        end
        @(negedge CLK);
        start = 1'b1; height = DIM_W'(h); width = DIM_W'(w); wr_ready = 1'b1; Vector_sig = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        total++;
        if (MVF_complete_sig !== 1'b0) begin
            bad++; $display("FAIL complete_drop: got %b expected 0", MVF_complete_sig);
        end
        total++;
        if (Nxt_block_sig !== 1'b1) begin
            bad++; $display("FAIL start_latency: Nxt_block_sig got %b expected 1", Nxt_block_sig);
        end
        while (!done && cyc < 3000) begin
            if (cyc > 0) @(negedge CLK);
            cyc++;
            start = 1'b0; height = DIM_W'(h); width = DIM_W'(w);
            Vector_sig = 1'b0; wr_ready = 1'b1;
            if (last_acc) begin
                total++;
                if (MVF_complete_sig !== 1'b1 || busy !== 1'b0) begin
                    bad++; $display("FAIL complete_rise: complete=%b busy=%b expected 1/0", MVF_complete_sig, busy);
                end
                done = 1;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        Vector_sig = 1'b1;
                        {mv_y, mv_x} = send_mv[wait_blk];
                    end
                end
                if (Nxt_block_sig === 1'b1) begin
                    reqs++;
                    total++;
                    if (exp_req_q.size() == 0) begin
                        bad++; $display("FAIL extra_req: got (%0d,%0d) expected none", addr_x, addr_y);
                    end else begin
                        ra = exp_req_q.pop_front();
                        if ({addr_y, addr_x} !== ra || busy !== 1'b1 || MVF_complete_sig !== 1'b0) begin
                            bad++; $display("FAIL req_addr: got y/x=%h busy=%b cpl=%b expected %h 1 0",
                                            {addr_y, addr_x}, busy, MVF_complete_sig, ra);
                        end
                    end
                    if (last_req_cyc >= 0 && reqs - 2 != stall_blk && reqs - 2 != drop_blk) begin
                        total++;
                        if (cyc - last_req_cyc != dly + 2) begin
                            bad++; $display("FAIL req_interval: got %0d expected %0d", cyc - last_req_cyc, dly + 2);
                        end
                    end
                    last_req_cyc = cyc;
                    wait_blk = reqs - 1;
                    if (wait_blk != drop_blk) pend = dly;
                    if (inject_start && reqs == 2) begin
                        start = 1'b1; height = DIM_W'(1); width = DIM_W'(1);
                    end
                end
                if (mvf_wr_en === 1'b1) begin
                    blk = wrs;
                    if (blk == drop_blk && en_cnt == 0) begin
                        total++;
                        if (cyc - last_req_cyc != 9 || timeout_flag !== 1'b1) begin
                            bad++; $display("FAIL timeout_write: delay=%0d flag=%b expected 9 1", cyc - last_req_cyc, timeout_flag);
                        end
                    end
                    total++;
                    if (exp_wr_q.size() == 0) begin
                        bad++; $display("FAIL extra_write: got addr %h expected none", mvf_wr_addr);
                    end else if ({mvf_wr_addr, mvf_wr_data} !== exp_wr_q[0] || Nxt_block_sig !== 1'b0) begin
                        bad++; $display("FAIL write: got addr/data %h nxt=%b expected %h 0",
                                        {mvf_wr_addr, mvf_wr_data}, Nxt_block_sig, exp_wr_q[0]);
                    end
                    en_cnt++;
                    if (blk == stall_blk && stall_left > 0) begin
                        wr_ready = 1'b0;
                        stall_left--;
                    end else begin
                        if (exp_wr_q.size() > 0) we = exp_wr_q.pop_front();
                        if (blk == stall_blk) begin
                            total++;
                            if (en_cnt != stall_len + 1) begin
                                bad++; $display("FAIL stall_hold: got %0d cycles expected %0d", en_cnt, stall_len + 1);
                            end
                        end
                        en_cnt = 0;
                        wrs++;
                        if (wrs == n) last_acc = 1;
                    end
                end
            end
        end
        total++;
        if (!done || reqs != n || wrs != n) begin
            bad++; $display("FAIL frame_count: done=%0d reqs=%0d writes=%0d expected 1 %0d %0d", done, reqs, wrs, n, n);
        end
        total++;
        if (timeout_flag !== (drop_blk >= 0)) begin
            bad++; $display("FAIL timeout_flag: got %b expected %b", timeout_flag, drop_blk >= 0);
        end
        $display("frame %0dx%0d: requests=%0d writes=%0d cycles=%0d", h, w, reqs, wrs, cyc);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; start = 1'b0; height = '0; width = '0;
        Vector_sig = 1'b0; mv_x = '0; mv_y = '0; wr_ready = 1'b1;
        #12;
        total++;
        if (all_outs() !== 64'd0) begin
            bad++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        total++;
        if (all_outs() !== 64'd0) begin
            bad++; $display("FAIL idle_outputs: got %h expected 0", all_outs());
        end
        $display("reset: outputs=%h", all_outs());
    endtask

    task automatic test_zero_dim();
        @(negedge CLK);
        start = 1'b1; height = DIM_W'(5); width = '0;
        @(negedge CLK);
        start = 1'b0;
        total++;
        if (MVF_complete_sig !== 1'b1 || busy !== 1'b0 || Nxt_block_sig !== 1'b0) begin
            bad++; $display("FAIL zero_dim: cpl=%b busy=%b nxt=%b expected 1 0 0", MVF_complete_sig, busy, Nxt_block_sig);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if (Nxt_block_sig !== 1'b0 || MVF_complete_sig !== 1'b1) begin
                bad++; $display("FAIL zero_dim_hold: nxt=%b cpl=%b expected 0 1", Nxt_block_sig, MVF_complete_sig);
            end
        end
        $display("zero_dim: complete=%b", MVF_complete_sig);
        run_frame(1, 1, 2, -1, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_pause_reset();
        @(negedge CLK);
        start = 1'b1; height = DIM_W'(3); width = DIM_W'(3);
        @(negedge CLK);
        start = 1'b0;
        total++;
        if (Nxt_block_sig !== 1'b1 || {addr_y, addr_x} !== 16'h0000) begin
            bad++; $display("FAIL pause_req: nxt=%b y/x=%h expected 1 0000", Nxt_block_sig, {addr_y, addr_x});
        end
        @(negedge CLK);
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            // A pulse while paused must be lost.
            Vector_sig = (i == 2);
            mv_x = 8'hAA; mv_y = 8'hBB;
            @(negedge CLK);
            Vector_sig = 1'b0;
            total++;
            if (busy !== 1'b1 || Nxt_block_sig !== 1'b0 || mvf_wr_en !== 1'b0 || {addr_y, addr_x} !== 16'h0000) begin
                bad++; $display("FAIL pause_hold: busy=%b nxt=%b wr=%b y/x=%h expected 1 0 0 0000",
                                busy, Nxt_block_sig, mvf_wr_en, {addr_y, addr_x});
            end
        end
        enable = 1'b1; Vector_sig = 1'b1; mv_x = 8'h12; mv_y = 8'h34;
        @(negedge CLK);
        Vector_sig = 1'b0;
        total++;
        if (mvf_wr_en !== 1'b1 || {mvf_wr_addr, mvf_wr_data} !== 32'h0000_3412) begin
            bad++; $display("FAIL resume_write: wr=%b addr/data=%h expected 1 00003412", mvf_wr_en, {mvf_wr_addr, mvf_wr_data});
        end
        wr_ready = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if (all_outs() !== 64'd0) begin
            bad++; $display("FAIL async_reset: got %h expected 0", all_outs());
        end
        @(negedge CLK);
        reset = 1'b0; wr_ready = 1'b1;
        @(negedge CLK);
        total++;
        if (all_outs() !== 64'd0) begin
            bad++; $display("FAIL post_reset_idle: got %h expected 0", all_outs());
        end
        $display("pause_reset: outputs after reset=%h", all_outs());
        run_frame(2, 2, 1, -1, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_raster_5x5();
        run_frame(5, 5, 3, -1, 0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_wrap_2x3();
        run_frame(2, 3, 3, -1, 0, 1'b1, 1'b1, -1);
    endtask

    task automatic test_back_pressure();
        run_frame(3, 3, 2, 2, 4, 1'b0, 1'b0, -1);
    endtask

`ifdef MVF_TIMEOUT_EN
    task automatic test_timeout();
        run_frame(2, 2, 3, -1, 0, 1'b0, 1'b0, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_raster_5x5();
        test_wrap_2x3();
        test_back_pressure();
        test_zero_dim();
        test_pause_reset();
`ifdef MVF_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
